combat_resolver: RTL and testbench
==================================

COMBAT_RESOLVER -- requirements
Module: combat_resolver

Interface
REQ-001 The block SHALL have one clock, `clk`; reset SHALL be `reset`, asynchronous and active-low (asserted when 0).
REQ-002 Parameters (name, default, meaning), one per line:
- TICK_DIV, 2500000: clk cycles per game tick (20 Hz at 50 MHz).
- SPRITE_W, 20: sprite width in pixels.
- SPRITE_H, 20: sprite height in pixels.
- REACH, 8: extra horizontal attack reach in pixels.
- DAMAGE, 10: health removed per hit.
- HEALTH_MAX, 100: starting health.
- STARTUP, 2: ticks spent in STARTUP.
- ACTIVE, 3: ticks spent in ACTIVE.
- RECOVERY, 4: ticks spent in RECOVERY.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset, in, 1, async active-low reset.
- p1_x / p1_y / p2_x / p2_y, in, 7 each, sprite positions from the physics engines.
- p1_attack / p2_attack, in, 1 each, attack button level.
- p1_colliding / p2_colliding, out, 1 each, sprite overlap flag for the physics engines.
- p1_phase / p2_phase, out, 2 each, attack phase: 0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY.
- p1_health / p2_health, out, 7 each, remaining health.
- p1_hit / p2_hit, out, 1 each, one-cycle pulse when that player is struck.
- game_over, out, 1, match ended.
- winner, out, 2, 00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-004 A tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; internal `tick` SHALL be high for exactly one clk when the count equals TICK_DIV-1.
REQ-005 The absolute differences dx=|p1_x-p2_x| and dy=|p1_y-p2_y| SHALL be computed unsigned in 7 bits with no wrap (the larger operand minus the smaller).
REQ-006 On every clk edge, both pN_colliding SHALL register (dx<SPRITE_W && dy<SPRITE_H); latency is 1 clk, with no dependence on tick or game_over.
REQ-007 Each attack button SHALL be sampled only on tick edges; a press is sample=1 while the previous sample was 0. A held button SHALL NOT re-trigger.
REQ-008 Per-player FSM, advancing only on tick edges:
- IDLE goes to STARTUP on a press.
- STARTUP goes to ACTIVE after STARTUP ticks.
- ACTIVE goes to RECOVERY after ACTIVE ticks.
- RECOVERY goes to IDLE after RECOVERY ticks.
- Presses outside IDLE SHALL be ignored.
- pN_phase SHALL reflect the current state.
REQ-009 Hit check: on each tick edge where the attacker's state is ACTIVE before the edge, a hit SHALL register if all of the following hold:
- dx <= SPRITE_W+REACH;
- dy < SPRITE_H;
- the attacker has not already hit during this attack.
The hit-done flag SHALL clear on IDLE->STARTUP.
REQ-010 On a hit, the defender's health SHALL decrease by DAMAGE on that same edge, saturating at 0; the defender's pN_hit SHALL be 1 for the next clk only.
REQ-011 Simultaneous hits by both players on the same tick SHALL both apply.
REQ-012 game_over SHALL be set on the clk after any health reaches 0; winner SHALL be:
- 01 if only p2_health is 0;
- 10 if only p1_health is 0;
- 11 if both are 0.
REQ-013 While game_over=1, the FSMs SHALL hold IDLE and health SHALL freeze; collision SHALL remain live. Only reset clears game_over.

Reset
REQ-014 On reset=0, the block SHALL immediately force:
- colliding, hit, game_over, winner, tick counter and button samples to 0;
- phases to IDLE;
- health to HEALTH_MAX.
This SHALL hold regardless of the operation in progress.
REQ-015 After reset deasserts, the first tick SHALL occur TICK_DIV clks later.

Verification (TICK_DIV=4, other parameters at default)
REQ-016 Collision: p1=(40,48), p2=(50,48) -> both colliding=1 one clk later; move p2_x to 60 -> both 0 one clk later.
REQ-017 Single hit: p1=(30,48), p2=(50,48) (dx=20), one p1 press -> phases 1,2,3,0 at tick boundaries (2/3/4 ticks); p2_health=90 with exactly one p2_hit pulse; p1_health=100.
REQ-018 Out of reach: p2_x=70 (dx=40), p1 press -> full FSM cycle, no hit, health 100/100. Holding p1_attack for 20 ticks -> exactly one attack.
REQ-019 Simultaneous: both players press on the same tick at dx=20 -> both healths 90 and both hit pulses on the same clk.
REQ-020 Knockout: 10 separate P1 hits -> p2_health=0 and never wraps; game_over=1 and winner=01; further presses ignored.
REQ-021 Reset mid-ACTIVE with p2_health=90 -> phases IDLE, health 100/100, game_over=0 immediately.

Source files
------------

// File: rtl/combat_resolver.sv
// Two-player melee resolver: registered sprite overlap, tick-paced attack
// state machines, reach-checked hits with saturating health and match outcome.
module combat_resolver #(
  parameter int TICK_DIV   = 2500000,
  parameter int SPRITE_W   = 20,
  parameter int SPRITE_H   = 20,
  parameter int REACH      = 8,
  parameter int DAMAGE     = 10,
  parameter int HEALTH_MAX = 100,
  parameter int STARTUP    = 2,
  parameter int ACTIVE     = 3,
  parameter int RECOVERY   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] p1_x,
  input  logic [6:0] p1_y,
  input  logic [6:0] p2_x,
  input  logic [6:0] p2_y,
  input  logic       p1_attack,
  input  logic       p2_attack,
  output logic       p1_colliding,
  output logic       p2_colliding,
  output logic [1:0] p1_phase,
  output logic [1:0] p2_phase,
  output logic [6:0] p1_health,
  output logic [6:0] p2_health,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_STARTUP  = 2'd1,
    PH_ACTIVE   = 2'd2,
    PH_RECOVERY = 2'd3
  } phase_t;

  localparam int            CW            = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST     = CW'(TICK_DIV - 1);
  localparam logic [7:0]    BODY_W        = 8'(SPRITE_W);
  localparam logic [7:0]    BODY_H        = 8'(SPRITE_H);
  localparam logic [7:0]    HIT_W         = 8'(SPRITE_W + REACH);
  localparam logic [6:0]    HP_MAX        = 7'(HEALTH_MAX);
  localparam logic [6:0]    HP_DMG        = 7'(DAMAGE);
  localparam logic [7:0]    STARTUP_LAST  = 8'(STARTUP - 1);
  localparam logic [7:0]    ACTIVE_LAST   = 8'(ACTIVE - 1);
  localparam logic [7:0]    RECOVERY_LAST = 8'(RECOVERY - 1);

  logic [CW-1:0] tick_cnt_q;
  logic          tick;
  logic [7:0]    dx;
  logic [7:0]    dy;
  logic          collide_q;
  logic          game_over_q;
  logic [1:0]    winner_q;
  logic [1:0]    atk;
  logic [1:0]    hit_w;
  logic [1:0]    hit_pulse;
  logic [3:0]    phase_w;
  logic [13:0]   health_w;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + CW'(1);
  end

  // Larger minus smaller so the distance never wraps.
  assign dx = (p1_x >= p2_x) ? {1'b0, p1_x - p2_x} : {1'b0, p2_x - p1_x};
  assign dy = (p1_y >= p2_y) ? {1'b0, p1_y - p2_y} : {1'b0, p2_y - p1_y};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collide_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      collide_q   <= (dx < BODY_W) && (dy < BODY_H);
      game_over_q <= game_over_q | (health_w[6:0] == 7'd0) | (health_w[13:7] == 7'd0);
      winner_q    <= {health_w[6:0] == 7'd0, health_w[13:7] == 7'd0};
    end
  end

  assign atk = {p2_attack, p1_attack};

  // Index gi is the attacker; its opponent (1-gi) takes the damage.
  for (genvar gi = 0; gi < 2; gi++) begin : g_player
    phase_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       samp_q;
    logic       done_q, done_d;
    logic       press;
    logic [6:0] health_q;
    logic       hit_q;

    assign press     = tick && atk[gi] && !samp_q;
    assign hit_w[gi] = tick && !game_over_q && (state_q == PH_ACTIVE) && !done_q
                       && (dx <= HIT_W) && (dy < BODY_H);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q | hit_w[gi];
      if (game_over_q) begin
        state_d = PH_IDLE;
        cnt_d   = '0;
      end else if (tick) begin
        case (state_q)
          PH_IDLE: if (press) begin
            state_d = PH_STARTUP;
            cnt_d   = '0;
            done_d  = 1'b0;
          end
          PH_STARTUP: if (cnt_q == STARTUP_LAST) begin
            state_d = PH_ACTIVE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 8'd1;
          PH_ACTIVE: if (cnt_q == ACTIVE_LAST) begin
            state_d = PH_RECOVERY;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 8'd1;
          PH_RECOVERY: if (cnt_q == RECOVERY_LAST) begin
            state_d = PH_IDLE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 8'd1;
          default: state_d = PH_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q  <= PH_IDLE;
        cnt_q    <= '0;
        samp_q   <= 1'b0;
        done_q   <= 1'b0;
        health_q <= HP_MAX;
        hit_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
        if (tick) samp_q <= atk[gi];
        if (hit_w[1-gi]) health_q <= (health_q < HP_DMG) ? 7'd0 : health_q - HP_DMG;
        hit_q <= hit_w[1-gi];
      end
    end

    assign phase_w[gi*2 +: 2]  = state_q;
    assign health_w[gi*7 +: 7] = health_q;
    assign hit_pulse[gi]       = hit_q;
  end

  assign p1_colliding = collide_q;
  assign p2_colliding = collide_q;
  assign p1_phase     = phase_w[1:0];
  assign p2_phase     = phase_w[3:2];
  assign p1_health    = health_w[6:0];
  assign p2_health    = health_w[13:7];
  assign p1_hit       = hit_pulse[0];
  assign p2_hit       = hit_pulse[1];
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Self-checking bench for combat_resolver: elapsed-tick behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_combat_resolver;
  localparam int TDIV = 4;
  localparam int SW = 20, SH = 20, RCH = 8, DMG = 10, HPMAX = 100;
  localparam int T_ST = 2, T_AC = 3, T_RC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] p1_x, p1_y, p2_x, p2_y;
  logic       p1_attack, p2_attack;
  logic       p1_colliding, p2_colliding;
  logic [1:0] p1_phase, p2_phase;
  logic [6:0] p1_health, p2_health;
  logic       p1_hit, p2_hit;
  logic       game_over;
  logic [1:0] winner;

  always #5 clk = ~clk;

  combat_resolver #(.TICK_DIV(TDIV)) dut (
    .clk(clk), .reset(reset),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_attack(p1_attack), .p2_attack(p2_attack),
    .p1_colliding(p1_colliding), .p2_colliding(p2_colliding),
    .p1_phase(p1_phase), .p2_phase(p2_phase),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .game_over(game_over), .winner(winner)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: an attack is remembered only by the tick number at which it began.
  int m_cycle, m_tickn;
  int m_start [2];
  bit m_done [2];
  bit m_samp [2];
  int m_health [2];
  bit m_hit [2];
  bit m_coll, m_go;
  int m_win;
  int md_dx, md_dy, md_bef;
  bit md_tk, md_go_n, md_pr;
  bit md_h [2];
  bit md_atk [2];
  int md_win_n;

  function automatic int phase_at(input int start, input int n);
    int e;
    if (start < 0) return 0;
    e = n - start;
    if (e < T_ST) return 1;
    if (e < T_ST + T_AC) return 2;
    if (e < T_ST + T_AC + T_RC) return 3;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cycle = 0; m_tickn = 0;
      for (int i = 0; i < 2; i++) begin
        m_start[i] = -1; m_done[i] = 0; m_samp[i] = 0;
        m_health[i] = HPMAX; m_hit[i] = 0;
      end
      m_coll = 0; m_go = 0; m_win = 0;
    end else begin
      md_dx = int'(p1_x) - int'(p2_x); if (md_dx < 0) md_dx = -md_dx;
      md_dy = int'(p1_y) - int'(p2_y); if (md_dy < 0) md_dy = -md_dy;
      md_atk[0] = p1_attack; md_atk[1] = p2_attack;
      md_tk = (m_cycle % TDIV) == TDIV - 1;
      m_cycle++;
      m_coll = (md_dx < SW) && (md_dy < SH);
      md_go_n = m_go || m_health[0] == 0 || m_health[1] == 0;
      md_win_n = ((m_health[0] == 0) ? 2 : 0) + ((m_health[1] == 0) ? 1 : 0);
      md_h[0] = 0; md_h[1] = 0;
      if (md_tk) begin
        m_tickn++;
        for (int i = 0; i < 2; i++) begin
          md_bef = phase_at(m_start[i], m_tickn - 1);
          md_h[i] = !m_go && md_bef == 2 && !m_done[i] && md_dx <= SW + RCH && md_dy < SH;
          md_pr = md_atk[i] && !m_samp[i];
          m_samp[i] = md_atk[i];
          if (!m_go && md_bef == 0 && md_pr) begin
            m_start[i] = m_tickn; m_done[i] = 0;
          end
          if (md_h[i]) m_done[i] = 1;
        end
      end
      if (m_go) begin m_start[0] = -1; m_start[1] = -1; end
      for (int i = 0; i < 2; i++)
        if (md_h[1-i]) m_health[i] = (m_health[i] > DMG) ? m_health[i] - DMG : 0;
      m_hit[0] = md_h[1]; m_hit[1] = md_h[0];
      m_go = md_go_n; m_win = md_win_n;
    end
  end

  // Per-cycle comparison and event bookkeeping for the directed checks.
  int cyc = 0, last_ph = 0, starts1 = 0;
  int seq [$];
  int hitcnt [2] = '{0, 0};
  int hitcyc [2] = '{-1, -1};

  always @(negedge clk) begin
    cyc++;
    chk("p1_colliding", int'(p1_colliding), int'(m_coll));
    chk("p2_colliding", int'(p2_colliding), int'(m_coll));
    chk("p1_phase", int'(p1_phase), phase_at(m_start[0], m_tickn));
    chk("p2_phase", int'(p2_phase), phase_at(m_start[1], m_tickn));
    chk("p1_health", int'(p1_health), m_health[0]);
    chk("p2_health", int'(p2_health), m_health[1]);
    chk("p1_hit", int'(p1_hit), int'(m_hit[0]));
    chk("p2_hit", int'(p2_hit), int'(m_hit[1]));
    chk("game_over", int'(game_over), int'(m_go));
    chk("winner", int'(winner), m_win);
    if (int'(p1_phase) != last_ph) begin
      seq.push_back(int'(p1_phase));
      if (last_ph == 0 && p1_phase == 2'd1) starts1++;
      last_ph = int'(p1_phase);
    end
    if (p1_hit) begin hitcnt[0]++; hitcyc[0] = cyc; end
    if (p2_hit) begin hitcnt[1]++; hitcyc[1] = cyc; end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_pos(input int ax, input int ay, input int bx, input int by);
    p1_x = 7'(ax); p1_y = 7'(ay); p2_x = 7'(bx); p2_y = 7'(by);
  endtask

  task automatic press(input bit a, input bit b);
    p1_attack = a; p2_attack = b;
    step(TDIV);
    p1_attack = 0; p2_attack = 0;
    step(TDIV);
  endtask

  task automatic do_reset();
    p1_attack = 0; p2_attack = 0;
    reset = 0;
    #1;
    chk("rst_p1_phase", int'(p1_phase), 0);
    chk("rst_p2_phase", int'(p2_phase), 0);
    chk("rst_p1_health", int'(p1_health), 100);
    chk("rst_p2_health", int'(p2_health), 100);
    chk("rst_game_over", int'(game_over), 0);
    step(2);
    reset = 1;
    seq.delete();
  endtask

  int hb0, hb1, s0;
  bit [7:0] sv;

  initial begin
    set_pos(10, 48, 100, 48);
    p1_attack = 0; p2_attack = 0;
    step(3);
    chk("init_p1_health", int'(p1_health), 100);
    chk("init_p2_phase", int'(p2_phase), 0);
    chk("init_winner", int'(winner), 0);
    reset = 1;

    // Collision follows position with one clock of latency.
    set_pos(40, 48, 50, 48);
    step(1);
    chk("coll_near_p1", int'(p1_colliding), 1);
    chk("coll_near_p2", int'(p2_colliding), 1);
    set_pos(40, 48, 60, 48);
    step(1);
    chk("coll_far_p1", int'(p1_colliding), 0);
    chk("coll_far_p2", int'(p2_colliding), 0);

    // Single hit at the edge of reach (dx = 20).
    set_pos(30, 48, 50, 48);
    seq.delete(); hb0 = hitcnt[0]; hb1 = hitcnt[1];
    press(1, 0);
    step(TDIV * 11);
    sv = 8'hFF;
    if (seq.size() == 4) sv = 8'((seq[0] << 6) | (seq[1] << 4) | (seq[2] << 2) | seq[3]);
    chk("single_phase_seq", int'(sv), 'h6C);
    chk("single_p2_health", int'(p2_health), 90);
    chk("single_p1_health", int'(p1_health), 100);
    chk("single_p2_hits", hitcnt[1] - hb1, 1);
    chk("single_p1_hits", hitcnt[0] - hb0, 0);

    // Out of reach, then a long hold that must trigger only once.
    do_reset();
    set_pos(30, 48, 70, 48);
    s0 = starts1;
    press(1, 0);
    step(TDIV * 11);
    chk("reach_p2_health", int'(p2_health), 100);
    chk("reach_p1_health", int'(p1_health), 100);
    chk("reach_attacks", starts1 - s0, 1);
    s0 = starts1;
    p1_attack = 1;
    step(TDIV * 20);
    p1_attack = 0;
    step(TDIV * 11);
    chk("hold_attacks", starts1 - s0, 1);

    // Simultaneous hits.
    do_reset();
    set_pos(30, 48, 50, 48);
    hb0 = hitcnt[0]; hb1 = hitcnt[1];
    press(1, 1);
    step(TDIV * 11);
    chk("simul_p1_health", int'(p1_health), 90);
    chk("simul_p2_health", int'(p2_health), 90);
    chk("simul_p1_hits", hitcnt[0] - hb0, 1);
    chk("simul_p2_hits", hitcnt[1] - hb1, 1);
    chk("simul_same_clk", hitcyc[0], hitcyc[1]);

    // Knockout after ten P1 hits.
    do_reset();
    set_pos(30, 48, 50, 48);
    hb1 = hitcnt[1];
    for (int k = 0; k < 10; k++) begin
      press(1, 0);
      step(TDIV * 10);
    end
    chk("ko_p2_health", int'(p2_health), 0);
    chk("ko_hits", hitcnt[1] - hb1, 10);
    chk("ko_game_over", int'(game_over), 1);
    chk("ko_winner", int'(winner), 1);
    s0 = starts1;
    press(1, 1);
    step(TDIV * 4);
    chk("ko_p1_phase", int'(p1_phase), 0);
    chk("ko_p2_phase", int'(p2_phase), 0);
    chk("ko_no_attack", starts1 - s0, 0);
    chk("ko_p2_frozen", int'(p2_health), 0);
    chk("ko_p1_frozen", int'(p1_health), 100);

    // Asynchronous reset in the middle of ACTIVE.
    do_reset();
    set_pos(30, 48, 50, 48);
    p1_attack = 1;
    for (int k = 0; k < 200 && p2_health != 7'd90; k++) step(1);
    chk("mid_wait_p2_health", int'(p2_health), 90);
    chk("mid_p1_active", int'(p1_phase), 2);
    do_reset();

    // Randomized play.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 7) == 0)
          set_pos(20 + $urandom_range(0, 60), 40 + $urandom_range(0, 20),
                  20 + $urandom_range(0, 60), 40 + $urandom_range(0, 20));
        if ($urandom_range(0, 5) == 0) p1_attack = ~p1_attack;
        if ($urandom_range(0, 5) == 0) p2_attack = ~p2_attack;
        step(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish before 2 ms");
    $fatal(1, "timeout");
  end

endmodule
